// File: rtl/vga_pattern_engine.sv
// Registered VGA test-pattern source: solid, checkerboard, static and bouncing square.
// Define VGA_SCROLL_EN to make the checkerboard scroll left one pixel per frame.
module vga_pattern_engine #(
    parameter int COLOR_W = 8,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CELL_W = 80,
    parameter int CELL_H = 60,
    parameter int SQ_SIZE = 16,
    parameter int STEP = 2,
    parameter logic [COLOR_W-1:0] FG_COLOR = 8'hFF,
    parameter logic [COLOR_W-1:0] BG_COLOR = 8'h00,
    parameter logic [COLOR_W-1:0] SOLID_COLOR = 8'h03
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [10:0]        hcount,
    input  logic [10:0]        vcount,
    input  logic               blank,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic [1:0]         mode,
    output logic [COLOR_W-1:0] rgb,
    output logic               hs_out,
    output logic               vs_out
);

    localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - SQ_SIZE);
    localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - SQ_SIZE);
    localparam logic [10:0] X_CENTRE = 11'((H_ACTIVE - SQ_SIZE) / 2);
    localparam logic [10:0] Y_CENTRE = 11'((V_ACTIVE - SQ_SIZE) / 2);
    localparam logic [11:0] SQ_EDGE  = 12'(SQ_SIZE);
    localparam logic [11:0] STEP_W   = 12'(STEP);

    typedef enum logic {DIR_POS, DIR_NEG} dir_t;

    dir_t        dx, dy, dx_next, dy_next;
    logic [10:0] sq_x, sq_y, sq_x_next, sq_y_next;
    logic [10:0] off;
    logic        frame_tick;
    logic [11:0] h_sum, cell_x, cell_y;
    logic        checker_odd, in_static, in_live;
    logic [COLOR_W-1:0] pixel;

    // Start of vertical blank, so the square never moves while it is being drawn.
    assign frame_tick = (hcount == 11'd0) && (vcount == 11'(V_ACTIVE));

`ifdef VGA_SCROLL_EN
    always_ff @(posedge clk) begin
        if (rst)
            off <= '0;
        else if (frame_tick && mode == 2'd1)
            off <= (off == 11'(2 * CELL_W - 1)) ? 11'd0 : off + 11'd1;
    end
`else
    assign off = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sq_x <= X_CENTRE;
            sq_y <= Y_CENTRE;
            dx   <= DIR_POS;
            dy   <= DIR_POS;
        end else begin
            sq_x <= sq_x_next;
            sq_y <= sq_y_next;
            dx   <= dx_next;
            dy   <= dy_next;
        end
    end

    // Both axes step in the same tick and clamp to the edge, so a corner hit flips both.
    always_comb begin
        sq_x_next = sq_x;
        sq_y_next = sq_y;
        dx_next   = dx;
        dy_next   = dy;
        if (frame_tick && mode == 2'd3) begin
            if (dx == DIR_POS) begin
                if ({1'b0, sq_x} + STEP_W >= {1'b0, X_MAX}) begin
                    sq_x_next = X_MAX;
                    dx_next   = DIR_NEG;
                end else begin
                    sq_x_next = sq_x + STEP_W[10:0];
                end
            end else begin
                if ({1'b0, sq_x} <= STEP_W) begin
                    sq_x_next = 11'd0;
                    dx_next   = DIR_POS;
                end else begin
                    sq_x_next = sq_x - STEP_W[10:0];
                end
            end
            if (dy == DIR_POS) begin
                if ({1'b0, sq_y} + STEP_W >= {1'b0, Y_MAX}) begin
                    sq_y_next = Y_MAX;
                    dy_next   = DIR_NEG;
                end else begin
                    sq_y_next = sq_y + STEP_W[10:0];
                end
            end else begin
                if ({1'b0, sq_y} <= STEP_W) begin
                    sq_y_next = 11'd0;
                    dy_next   = DIR_POS;
                end else begin
                    sq_y_next = sq_y - STEP_W[10:0];
                end
            end
        end
    end

    always_comb begin
        h_sum       = {1'b0, hcount} + {1'b0, off};
        cell_x      = h_sum / 12'(CELL_W);
        cell_y      = {1'b0, vcount} / 12'(CELL_H);
        checker_odd = cell_x[0] ^ cell_y[0];
        in_static   = (hcount >= X_CENTRE) && ({1'b0, hcount} < {1'b0, X_CENTRE} + SQ_EDGE) &&
                      (vcount >= Y_CENTRE) && ({1'b0, vcount} < {1'b0, Y_CENTRE} + SQ_EDGE);
        in_live     = (hcount >= sq_x) && ({1'b0, hcount} < {1'b0, sq_x} + SQ_EDGE) &&
                      (vcount >= sq_y) && ({1'b0, vcount} < {1'b0, sq_y} + SQ_EDGE);
        pixel = BG_COLOR;
        if (blank) begin
            pixel = '0;
        end else begin
            case (mode)
                2'd0: pixel = SOLID_COLOR;
                2'd1: pixel = checker_odd ? FG_COLOR : BG_COLOR;
                2'd2: pixel = in_static ? FG_COLOR : BG_COLOR;
                default: pixel = in_live ? FG_COLOR : BG_COLOR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb    <= '0;
            hs_out <= 1'b0;
            vs_out <= 1'b0;
        end else begin
            rgb    <= pixel;
            hs_out <= hs_in;
            vs_out <= vs_in;
        end
    end

endmodule

// File: tb/tb_vga_pattern_engine.sv
// Randomised self-checking bench for vga_pattern_engine against a frame-level reference model.
// Follows VGA_SCROLL_EN the same way the design does.
module tb_vga_pattern_engine;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int SQ_SIZE = 16;
    localparam int STEP = 2;
    localparam int X_MAX = H_ACTIVE - SQ_SIZE;
    localparam int Y_MAX = V_ACTIVE - SQ_SIZE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount = '0;
    logic [10:0] vcount = '0;
    logic        blank = 1'b0;
    logic        hs_in = 1'b0;
    logic        vs_in = 1'b0;
    logic [1:0]  mode = '0;
    logic [7:0]  rgb;
    logic        hs_out;
    logic        vs_out;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model: square position/direction and scroll offset.
    int mx = 312, my = 232, mdx = 1, mdy = 1, moff = 0;

    vga_pattern_engine dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .blank(blank),
        .hs_in(hs_in), .vs_in(vs_in), .mode(mode), .rgb(rgb), .hs_out(hs_out), .vs_out(vs_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int inSquare(input int h, input int v, input int x, input int y);
        return (h >= x && h < x + SQ_SIZE && v >= y && v < y + SQ_SIZE) ? 1 : 0;
    endfunction

    function automatic int modelPixel(input int h, input int v, input int b, input int m);
        if (b != 0) return 0;
        case (m)
            0: return 8'h03;
            1: return ((((h + moff) / 80) ^ (v / 60)) & 1) != 0 ? 8'hFF : 8'h00;
            2: return inSquare(h, v, 312, 232) != 0 ? 8'hFF : 8'h00;
            default: return inSquare(h, v, mx, my) != 0 ? 8'hFF : 8'h00;
        endcase
    endfunction

    task automatic modelBounce(inout int p, inout int d, input int pmax);
        if (d > 0) begin
            if (p + STEP >= pmax) begin p = pmax; d = -1; end
            else p = p + STEP;
        end else begin
            if (p <= STEP) begin p = 0; d = 1; end
            else p = p - STEP;
        end
    endtask

    task automatic applyStimulus(input string tag, input int h, input int v, input int b,
                                 input int hsi, input int vsi, input int m, input int r);
        int expRgb, expHs, expVs;
        @(negedge clk);
        hcount = 11'(h);
        vcount = 11'(v);
        blank  = b[0];
        hs_in  = hsi[0];
        vs_in  = vsi[0];
        mode   = 2'(m);
        rst    = r[0];
        if (r != 0) begin
            expRgb = 0; expHs = 0; expVs = 0;
            mx = 312; my = 232; mdx = 1; mdy = 1; moff = 0;
        end else begin
            expRgb = modelPixel(h, v, b, m);
            expHs = hsi;
            expVs = vsi;
            if (h == 0 && v == V_ACTIVE) begin
                if (m == 3) begin
                    modelBounce(mx, mdx, X_MAX);
                    modelBounce(my, mdy, Y_MAX);
                end
`ifdef VGA_SCROLL_EN
                if (m == 1) moff = (moff + 1) % 160;
`endif
            end
        end
        @(posedge clk);
        #1;
        checkOutput({tag, ".rgb"}, int'(rgb), expRgb);
        checkOutput({tag, ".hs"}, int'(hs_out), expHs);
        checkOutput({tag, ".vs"}, int'(vs_out), expVs);
    endtask

    task automatic frameTick(input int m);
        applyStimulus("tick", 0, V_ACTIVE, 1, 0, 1, m, 0);
    endtask

    initial begin
        int h, v, m, b;
        $display("[TB] start");
        for (int i = 0; i < 3; i++)
            applyStimulus("reset", $urandom_range(0, 799), $urandom_range(0, 524),
                          $urandom_range(0, 1), 1, 1, $urandom_range(0, 3), 1);

        applyStimulus("solid", 10, 10, 0, 0, 0, 0, 0);
        applyStimulus("solid_hs", 11, 10, 0, 1, 0, 0, 0);
        applyStimulus("solid_blank", 12, 10, 1, 0, 0, 0, 0);
        checkOutput("solid_const", int'(rgb), 0);

        applyStimulus("chk_79_0", 79, 0, 0, 0, 0, 1, 0);
        applyStimulus("chk_80_0", 80, 0, 0, 0, 0, 1, 0);
        checkOutput("chk_80_0_const", int'(rgb), 8'hFF);
        applyStimulus("chk_80_60", 80, 60, 0, 0, 0, 1, 0);
        applyStimulus("chk_639_479", 639, 479, 0, 0, 0, 1, 0);
        applyStimulus("chk_blank", 80, 0, 1, 0, 0, 1, 0);

        applyStimulus("st_312_232", 312, 232, 0, 0, 0, 2, 0);
        applyStimulus("st_327_247", 327, 247, 0, 0, 0, 2, 0);
        checkOutput("st_327_247_const", int'(rgb), 8'hFF);
        applyStimulus("st_311_232", 311, 232, 0, 0, 0, 2, 0);
        applyStimulus("st_328_240", 328, 240, 0, 0, 0, 2, 0);

        frameTick(3);
        applyStimulus("bnc_first", 314, 234, 0, 0, 0, 3, 0);
        checkOutput("bnc_first_const", int'(rgb), 8'hFF);
        applyStimulus("bnc_first_out", 313, 234, 0, 0, 0, 3, 0);
        for (int i = 2; i <= 156; i++) begin
            frameTick(3);
            if (i == 116) begin
                applyStimulus("bnc_y464", 544, 464, 0, 0, 0, 3, 0);
                checkOutput("bnc_y464_const", int'(rgb), 8'hFF);
                applyStimulus("bnc_y463", 544, 463, 0, 0, 0, 3, 0);
            end
        end
        applyStimulus("bnc_156", 624, 384, 0, 0, 0, 3, 0);
        checkOutput("bnc_156_const", int'(rgb), 8'hFF);
        applyStimulus("bnc_156_out", 623, 384, 0, 0, 0, 3, 0);
        frameTick(3);
        applyStimulus("bnc_157", 622, 382, 0, 0, 0, 3, 0);
        checkOutput("bnc_157_const", int'(rgb), 8'hFF);
        applyStimulus("bnc_157_out", 638, 382, 0, 0, 0, 3, 0);
        for (int i = 0; i < 10; i++) frameTick(1);
        applyStimulus("bnc_held", 622, 382, 0, 0, 0, 3, 0);
        checkOutput("bnc_held_const", int'(rgb), 8'hFF);

        for (int i = 0; i < 3000; i++) begin
            m = $urandom_range(0, 3);
            b = ($urandom_range(0, 7) == 0) ? 1 : 0;
            if ($urandom_range(0, 9) == 0) begin
                h = 0; v = V_ACTIVE; b = 1;
            end else if (m >= 2 && $urandom_range(0, 1) == 1) begin
                h = ((m == 3) ? mx : 312) + $urandom_range(0, 20) - 2;
                v = ((m == 3) ? my : 232) + $urandom_range(0, 20) - 2;
                if (h < 0) h = 0;
                if (v < 0) v = 0;
            end else begin
                h = $urandom_range(0, 799);
                v = $urandom_range(0, 524);
            end
            if ($urandom_range(0, 9) < 4 && h == 0 && v == V_ACTIVE) m = 3;
            applyStimulus("rand", h, v, b, $urandom_range(0, 1), $urandom_range(0, 1), m,
                          ($urandom_range(0, 199) == 0) ? 1 : 0);
        end

        applyStimulus("scroll_rst", 0, 0, 0, 0, 0, 1, 1);
        frameTick(1);
        applyStimulus("scroll_78", 78, 0, 0, 0, 0, 1, 0);
        applyStimulus("scroll_79", 79, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i < 160; i++) frameTick(1);
        applyStimulus("scroll_wrap", 79, 0, 0, 0, 0, 1, 0);
        checkOutput("scroll_wrap_const", int'(rgb), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
